// File: rtl/parity_memory_writer_if.sv
// Write-bus / S-register / erasable-memory signal bundle for parity_memory_writer.
// master is the writer side; slave is the request source plus memory model side.
interface parity_memory_writer_if;
    logic        WRREQ;
    logic [15:0] WL_n;
    logic [11:0] S_ADDR;
    logic        TSUDO_n;
    logic [11:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic        MEM_WE;
    logic        MEM_RE;
    logic [15:0] MEM_RDATA;
    logic        BUSY;
    logic        WRDONE;
    logic        PALARM;
    logic        PALCLR;

    modport master (
        input  WRREQ, WL_n, S_ADDR, TSUDO_n, MEM_RDATA, PALCLR,
        output MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, BUSY, WRDONE, PALARM
    );

    modport slave (
        output WRREQ, WL_n, S_ADDR, TSUDO_n, MEM_RDATA, PALCLR,
        input  MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, BUSY, WRDONE, PALARM
    );
endinterface

// File: rtl/parity_memory_writer.sv
// Latches an active-low write-bus word and S-register address, inserts odd parity in bit 15 and
// strobes the erasable-memory model. Define PARITY_READBACK_EN to add readback and the parity alarm.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for WRREQ; word/address/parity latched on accept
// ST_GEN   | one clock with address and parity-complete word valid
// ST_WRITE | MEM_WE held for WE_CYCLES clocks
// ST_READ  | MEM_RE held for RD_CYCLES clocks, data sampled on last
// ST_CHECK | readback parity/compare, may set PALARM
// ST_DONE  | WRDONE pulse
module parity_memory_writer #(
    parameter int WE_CYCLES = 3,
    parameter int RD_CYCLES = 2
) (
    input  logic                   SIM_CLK,
    input  logic                   SIM_RST,
    input  logic                   GOJAM,
    parity_memory_writer_if.master bus
);

    if (WE_CYCLES < 1 || WE_CYCLES > 15) begin : g_bad_we_cycles
        $fatal(1, "parity_memory_writer: WE_CYCLES must be 1..15");
    end
    if (RD_CYCLES < 1 || RD_CYCLES > 15) begin : g_bad_rd_cycles
        $fatal(1, "parity_memory_writer: RD_CYCLES must be 1..15");
    end

    localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_WRITE,
        ST_READ,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        latch_en;

    logic [11:0] addr_q;
    logic [13:0] data_q;
    logic        sign_q;
    logic        parity_q;

    logic [13:0] data_w;
    logic        sign_w;
    logic        parity_w;
    logic [15:0] wdata;

    // Write line 15 carries no data; the parity bit is generated here instead.
    logic        unused_wl_bit15;
    assign unused_wl_bit15 = bus.WL_n[14];

    assign data_w   = ~bus.WL_n[13:0];
    assign sign_w   = ~bus.WL_n[15];
    assign parity_w = ~(^{sign_w, data_w}) ^ ~bus.TSUDO_n;
    assign wdata    = {sign_q, parity_q, data_q};

`ifdef PARITY_READBACK_EN
    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);

    logic        sample_en;
    logic        check_en;
    logic        tsudo_q;
    logic [15:0] rdata_q;
    logic        palarm_q;
    logic        rd_match;
    logic        rd_odd;
    logic        alarm_set;
`endif

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST || GOJAM) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
`ifdef PARITY_READBACK_EN
        sample_en = 1'b0;
        check_en  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.WRREQ) begin
                    latch_en = 1'b1;
                    state_d  = ST_GEN;
                end
            end
            ST_GEN: begin
                cnt_d   = WE_LOAD;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (cnt_q == 4'd0) begin
`ifdef PARITY_READBACK_EN
                    cnt_d   = RD_LOAD;
                    state_d = ST_READ;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef PARITY_READBACK_EN
            ST_READ: begin
                if (cnt_q == 4'd0) begin
                    sample_en = 1'b1;
                    state_d   = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CHECK: begin
                check_en = 1'b1;
                state_d  = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // An abort discards everything in flight, including a pending alarm update.
        if (GOJAM) begin
            latch_en = 1'b0;
`ifdef PARITY_READBACK_EN
            sample_en = 1'b0;
            check_en  = 1'b0;
`endif
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST || GOJAM) begin
            addr_q   <= '0;
            data_q   <= '0;
            sign_q   <= 1'b0;
            parity_q <= 1'b0;
        end else if (latch_en) begin
            addr_q   <= bus.S_ADDR;
            data_q   <= data_w;
            sign_q   <= sign_w;
            parity_q <= parity_w;
        end
    end

`ifdef PARITY_READBACK_EN
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST || GOJAM) begin
            tsudo_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (latch_en) begin
                tsudo_q <= ~bus.TSUDO_n;
            end
            if (sample_en) begin
                rdata_q <= bus.MEM_RDATA;
            end
        end
    end

    // A deliberate bad-parity write that reads back intact is the expected outcome, not a fault.
    assign rd_match  = (rdata_q == wdata);
    assign rd_odd    = ^rdata_q;
    assign alarm_set = check_en && (!rd_odd || !rd_match) && !(tsudo_q && rd_match);

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            palarm_q <= 1'b0;
        end else if (alarm_set) begin
            palarm_q <= 1'b1;
        end else if (bus.PALCLR && !GOJAM) begin
            palarm_q <= 1'b0;
        end
    end

    assign bus.MEM_RE = (state_q == ST_READ);
    assign bus.PALARM = palarm_q;
`else
    logic unused_readback;
    assign unused_readback = ^{bus.MEM_RDATA, bus.PALCLR};

    assign bus.MEM_RE = 1'b0;
    assign bus.PALARM = 1'b0;
`endif

    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_WDATA = wdata;
    assign bus.MEM_WE    = (state_q == ST_WRITE);
    assign bus.BUSY      = (state_q != ST_IDLE);
    assign bus.WRDONE    = (state_q == ST_DONE);

endmodule

// File: tb/tb_parity_memory_writer.sv
// Directed self-checking bench for parity_memory_writer; adapts to the PARITY_READBACK_EN build.
`timescale 1ns/1ps
module tb_parity_memory_writer;

    localparam int WE_N = 3;
`ifdef PARITY_READBACK_EN
    localparam int RB_EXTRA = 3;
    localparam int RD_N     = 2;
`else
    localparam int RB_EXTRA = 0;
    localparam int RD_N     = 0;
`endif
    localparam int SPACING = 3 + WE_N + RB_EXTRA;
    localparam int DONE_AT = 2 + WE_N + RB_EXTRA;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST;
    logic        GOJAM;
    logic [15:0] mem_word;
    logic [15:0] force_val;
    logic        force_en;
    int          checks = 0;
    int          errors = 0;

    parity_memory_writer_if bus();

    parity_memory_writer #(.WE_CYCLES(WE_N), .RD_CYCLES(2)) dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .GOJAM   (GOJAM),
        .bus     (bus)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    always @(posedge SIM_CLK) begin
        if (bus.MEM_WE) mem_word <= bus.MEM_WDATA;
    end
    assign bus.MEM_RDATA = force_en ? force_val : mem_word;

    task automatic tick();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic run_write(input logic [15:0] wl, input logic [11:0] a, input logic t,
                             output int we_n, output int re_n, output int first_we,
                             output int done_n, output int done_at,
                             output logic [15:0] wd, output logic [11:0] ad, output int changes);
        bus.WL_n = wl; bus.S_ADDR = a; bus.TSUDO_n = t; bus.WRREQ = 1'b1;
        tick();
        bus.WRREQ = 1'b0; bus.WL_n = ~wl; bus.S_ADDR = ~a; bus.TSUDO_n = 1'b1;
        wd = bus.MEM_WDATA; ad = bus.MEM_ADDR;
        we_n = 0; re_n = 0; first_we = -1; done_n = 0; done_at = -1; changes = 0;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (bus.MEM_WE) begin
                we_n++;
                if (first_we < 0) first_we = i;
            end
            if (bus.MEM_RE) re_n++;
            if (bus.WRDONE) begin
                done_n++;
                done_at = i;
            end
            if (bus.MEM_WDATA !== wd || bus.MEM_ADDR !== ad) changes++;
        end
    endtask

    task automatic test_reset();
        logic [44:0] outs;
        SIM_RST = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", bus.BUSY);
        end
        SIM_RST = 1'b0;
        tick();
        outs = {bus.MEM_ADDR, bus.MEM_WDATA, bus.MEM_WE, bus.MEM_RE, bus.BUSY, bus.WRDONE,
                bus.PALARM, 12'h000};
        checks++;
        if (outs !== 45'd0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", outs);
        end
    endtask

    task automatic test_reset_mid();
        bus.WL_n = 16'hFFFE; bus.S_ADDR = 12'o0321; bus.TSUDO_n = 1'b1; bus.WRREQ = 1'b1;
        tick();
        bus.WRREQ = 1'b0;
        tick();
        checks++;
        if (bus.MEM_WE !== 1'b1) begin
            errors++; $display("FAIL mid_reset_we_before got %b want 1", bus.MEM_WE);
        end
        SIM_RST = 1'b1;
        tick();
        SIM_RST = 1'b0;
        checks++;
        if ({bus.MEM_WE, bus.BUSY, bus.WRDONE, bus.MEM_WDATA, bus.MEM_ADDR} !== 31'd0) begin
            errors++; $display("FAIL mid_reset got we=%b busy=%b done=%b wd=%h ad=%o want all 0",
                               bus.MEM_WE, bus.BUSY, bus.WRDONE, bus.MEM_WDATA, bus.MEM_ADDR);
        end
        tick();
    endtask

    task automatic test_parity_gen();
        int we_n, re_n, first_we, done_n, done_at, changes;
        logic [15:0] wd;
        logic [11:0] ad;
        run_write(16'hFFFE, 12'o1234, 1'b1, we_n, re_n, first_we, done_n, done_at, wd, ad, changes);
        checks++;
        if (wd !== 16'h0001) begin errors++; $display("FAIL gen_wdata got %h want 0001", wd); end
        checks++;
        if (ad !== 12'o1234) begin errors++; $display("FAIL gen_addr got %o want 1234", ad); end
        checks++;
        if (we_n !== WE_N) begin errors++; $display("FAIL gen_we_len got %0d want %0d", we_n, WE_N); end
        checks++;
        if (first_we !== 2) begin errors++; $display("FAIL gen_we_start got %0d want 2", first_we); end
        checks++;
        if (re_n !== RD_N) begin errors++; $display("FAIL gen_re_len got %0d want %0d", re_n, RD_N); end
        checks++;
        if (done_n !== 1 || done_at !== DONE_AT) begin
            errors++; $display("FAIL gen_wrdone got n=%0d at=%0d want n=1 at=%0d", done_n, done_at, DONE_AT);
        end
        checks++;
        if (changes !== 0) begin errors++; $display("FAIL gen_stable got %0d changes want 0", changes); end
        checks++;
        if (bus.BUSY !== 1'b0 || bus.PALARM !== 1'b0) begin
            errors++; $display("FAIL gen_idle got busy=%b palarm=%b want 0 0", bus.BUSY, bus.PALARM);
        end
    endtask

    task automatic test_word_patterns();
        logic [15:0] wl_tab  [7] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'hBFFF, 16'h0000, 16'hFFFE, 16'hAAAA};
        logic        ts_tab  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] exp_tab [7] = '{16'h4000, 16'h0000, 16'h8000, 16'h4000, 16'hBFFF, 16'h4001, 16'h1555};
        int we_n, re_n, first_we, done_n, done_at, changes;
        logic [15:0] wd;
        logic [11:0] ad;
        for (int k = 0; k < 7; k++) begin
            run_write(wl_tab[k], 12'(k * 3 + 1), ts_tab[k], we_n, re_n, first_we, done_n, done_at,
                      wd, ad, changes);
            checks++;
            if (wd !== exp_tab[k] || done_n !== 1) begin
                errors++; $display("FAIL pattern_%0d got wd=%h done=%0d want wd=%h done=1",
                                   k, wd, done_n, exp_tab[k]);
            end
            checks++;
            if (bus.PALARM !== 1'b0) begin
                errors++; $display("FAIL pattern_%0d_palarm got %b want 0", k, bus.PALARM);
            end
        end
    endtask

`ifdef PARITY_READBACK_EN
    task automatic test_readback();
        int we_n, re_n, first_we, done_n, done_at, changes;
        logic [15:0] wd;
        logic [11:0] ad;
        force_en = 1'b1; force_val = 16'h4001;
        run_write(16'hFFFF, 12'o0100, 1'b1, we_n, re_n, first_we, done_n, done_at, wd, ad, changes);
        force_en = 1'b0;
        checks++;
        if (bus.PALARM !== 1'b1) begin errors++; $display("FAIL rb_even_set got %b want 1", bus.PALARM); end
        run_write(16'hFFFE, 12'o0200, 1'b1, we_n, re_n, first_we, done_n, done_at, wd, ad, changes);
        checks++;
        if (bus.PALARM !== 1'b1) begin errors++; $display("FAIL rb_sticky got %b want 1", bus.PALARM); end
        bus.PALCLR = 1'b1;
        tick();
        bus.PALCLR = 1'b0;
        checks++;
        if (bus.PALARM !== 1'b0) begin errors++; $display("FAIL rb_clear got %b want 0", bus.PALARM); end

        // set and clear on the same edge: set wins
        force_en = 1'b1; force_val = 16'h0000;
        bus.WL_n = 16'hFFFF; bus.S_ADDR = 12'o0300; bus.TSUDO_n = 1'b1; bus.WRREQ = 1'b1;
        tick();
        bus.WRREQ = 1'b0;
        for (int i = 2; i <= 7; i++) tick();
        checks++;
        if (bus.PALARM !== 1'b0) begin errors++; $display("FAIL rb_before_check got %b want 0", bus.PALARM); end
        bus.PALCLR = 1'b1;
        tick();
        bus.PALCLR = 1'b0;
        force_en = 1'b0;
        checks++;
        if (bus.PALARM !== 1'b1) begin errors++; $display("FAIL rb_set_priority got %b want 1", bus.PALARM); end
        tick();
        bus.PALCLR = 1'b1;
        tick();
        bus.PALCLR = 1'b0;

        force_en = 1'b1; force_val = 16'h4000;
        run_write(16'hFFFF, 12'o0400, 1'b0, we_n, re_n, first_we, done_n, done_at, wd, ad, changes);
        checks++;
        if (bus.PALARM !== 1'b1) begin errors++; $display("FAIL rb_tsudo_mismatch got %b want 1", bus.PALARM); end
        bus.PALCLR = 1'b1;
        tick();
        bus.PALCLR = 1'b0;
        force_val = 16'h0001;
        run_write(16'hFFFF, 12'o0500, 1'b1, we_n, re_n, first_we, done_n, done_at, wd, ad, changes);
        force_en = 1'b0;
        checks++;
        if (bus.PALARM !== 1'b1) begin errors++; $display("FAIL rb_data_mismatch got %b want 1", bus.PALARM); end
        bus.PALCLR = 1'b1;
        tick();
        bus.PALCLR = 1'b0;
    endtask
`else
    task automatic test_readback();
        int we_n, re_n, first_we, done_n, done_at, changes;
        logic [15:0] wd;
        logic [11:0] ad;
        force_en = 1'b1; force_val = 16'h4001;
        bus.PALCLR = 1'b0;
        run_write(16'hFFFF, 12'o0100, 1'b1, we_n, re_n, first_we, done_n, done_at, wd, ad, changes);
        force_en = 1'b0;
        checks++;
        if (bus.PALARM !== 1'b0 || re_n !== 0) begin
            errors++; $display("FAIL no_readback got palarm=%b re=%0d want 0 0", bus.PALARM, re_n);
        end
    endtask
`endif

    task automatic test_abort();
        int we_n, re_n, first_we, done_n, done_at, changes, late_done;
        logic [15:0] wd;
        logic [11:0] ad;
        logic        exp_pal;
`ifdef PARITY_READBACK_EN
        force_en = 1'b1; force_val = 16'h4001;
        run_write(16'hFFFF, 12'o0600, 1'b1, we_n, re_n, first_we, done_n, done_at, wd, ad, changes);
        force_en = 1'b0;
        exp_pal = 1'b1;
`else
        exp_pal = 1'b0;
`endif
        bus.WL_n = 16'hFFFE; bus.S_ADDR = 12'o0777; bus.TSUDO_n = 1'b1; bus.WRREQ = 1'b1;
        tick();
        bus.WRREQ = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.MEM_WE !== 1'b1) begin errors++; $display("FAIL abort_we_second got %b want 1", bus.MEM_WE); end
        GOJAM = 1'b1;
        tick();
        GOJAM = 1'b0;
        checks++;
        if (bus.MEM_WE !== 1'b0 || bus.BUSY !== 1'b0 || bus.WRDONE !== 1'b0) begin
            errors++; $display("FAIL abort_drop got we=%b busy=%b done=%b want 0 0 0",
                               bus.MEM_WE, bus.BUSY, bus.WRDONE);
        end
        checks++;
        if (bus.PALARM !== exp_pal) begin
            errors++; $display("FAIL abort_palarm_held got %b want %b", bus.PALARM, exp_pal);
        end
        late_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.WRDONE) late_done++;
        end
        checks++;
        if (late_done !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", late_done); end
        run_write(16'hFFFF, 12'o0555, 1'b1, we_n, re_n, first_we, done_n, done_at, wd, ad, changes);
        checks++;
        if (done_n !== 1 || we_n !== WE_N || wd !== 16'h4000 || ad !== 12'o0555) begin
            errors++; $display("FAIL abort_recover got done=%0d we=%0d wd=%h ad=%o want 1 %0d 4000 555",
                               done_n, we_n, wd, ad, WE_N);
        end
        bus.PALCLR = 1'b1;
        tick();
        bus.PALCLR = 1'b0;
    endtask

    task automatic test_back_to_back();
        int done_edges [3];
        int n_done, we_total, extra;
        n_done = 0; we_total = 0; extra = 0;
        bus.WL_n = 16'hFFFE; bus.S_ADDR = 12'o0042; bus.TSUDO_n = 1'b1; bus.WRREQ = 1'b1;
        for (int i = 1; i <= 3 * SPACING; i++) begin
            tick();
            if (bus.MEM_WE) we_total++;
            if (bus.WRDONE) begin
                if (n_done < 3) done_edges[n_done] = i;
                n_done++;
            end
        end
        bus.WRREQ = 1'b0;
        for (int i = 0; i < 2 * SPACING; i++) begin
            tick();
            if (bus.WRDONE) extra++;
        end
        checks++;
        if (n_done !== 3 || extra !== 0) begin
            errors++; $display("FAIL b2b_done_count got %0d+%0d want 3+0", n_done, extra);
        end
        checks++;
        if (done_edges[0] !== DONE_AT || done_edges[1] - done_edges[0] !== SPACING ||
            done_edges[2] - done_edges[1] !== SPACING) begin
            errors++; $display("FAIL b2b_spacing got %0d %0d %0d want %0d step %0d",
                               done_edges[0], done_edges[1], done_edges[2], DONE_AT, SPACING);
        end
        checks++;
        if (we_total !== 3 * WE_N) begin
            errors++; $display("FAIL b2b_we_total got %0d want %0d", we_total, 3 * WE_N);
        end
    endtask

    initial begin
        SIM_RST = 1'b1; GOJAM = 1'b0; force_en = 1'b0; force_val = 16'h0000;
        bus.WRREQ = 1'b0; bus.WL_n = 16'hFFFF; bus.S_ADDR = 12'o0000;
        bus.TSUDO_n = 1'b1; bus.PALCLR = 1'b0;
        test_reset();
        test_reset_mid();
        test_parity_gen();
        test_word_patterns();
        test_readback();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
